// File: rtl/rgb_pwm_ctrl.sv
// Purpose     : multi-channel PWM (OFF / STATIC / BREATHE / BLINK) driving the iCE40 SB_RGBA_DRV RGBnPWM inputs.
// Latency     : config writes apply at the next PWM period start; pwm_out is registered one hw_clk behind pwm_cnt.
// Backpressure: none; cfg_ready is high whenever out of reset and a write can be accepted every cycle.
//
// Ports:
//   hw_clk, rst_n          clock, asynchronous active-low reset (synchronous release expected upstream)
//   cfg_valid / cfg_ready  config write handshake; cfg_ch, cfg_mode, cfg_duty carry the write
//   cfg_err                one-cycle pulse after an accepted write to a channel index >= NUM_CH
//   pwm_out                registered per-channel PWM outputs
//   period_strobe          one-cycle pulse, one cycle after each PWM period start
//
// Optional: define RGB_PWM_GAMMA_EN to apply a square-law gamma ((eff*eff) >> PWM_W)
// to the effective duty before the compare.
module rgb_pwm_ctrl #(
    parameter int NUM_CH     = 3,
    parameter int PWM_W      = 8,
    parameter int PRESCALE   = 4,
    parameter int BREATH_DIV = 2,
    parameter int BLINK_DIV  = 64
) (
    input  logic              hw_clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [2:0]        cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [PWM_W-1:0]  cfg_duty,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_strobe
);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_STATIC  = 2'b01,
        MODE_BREATHE = 2'b10,
        MODE_BLINK   = 2'b11
    } mode_e;

    localparam int PS_W = (PRESCALE   > 1) ? $clog2(PRESCALE)   : 1;
    localparam int BD_W = (BREATH_DIV > 1) ? $clog2(BREATH_DIV) : 1;
    localparam int BK_W = (BLINK_DIV  > 1) ? $clog2(BLINK_DIV)  : 1;

    localparam logic [PS_W-1:0]  PS_LAST    = PS_W'(PRESCALE - 1);
    localparam logic [BD_W-1:0]  BD_LAST    = BD_W'(BREATH_DIV - 1);
    localparam logic [BK_W-1:0]  BK_LAST    = BK_W'(BLINK_DIV - 1);
    localparam logic [PWM_W-1:0] CNT_LAST   = {PWM_W{1'b1}};
    localparam logic [PWM_W-1:0] LVL_TOP_M1 = CNT_LAST - 1'b1;
    localparam logic [3:0]       NUM_CH_L   = 4'(NUM_CH);

    logic [PS_W-1:0]   presc;
    logic [PWM_W-1:0]  pwm_cnt;
    logic [BK_W-1:0]   blink_cnt;
    logic              blink_ph;
    logic              tick;
    logic              pstart;
    logic              cfg_acc;
    logic              ch_ok;
    logic [NUM_CH-1:0] pwm_nxt;

    assign tick    = (presc == PS_LAST);
    // Period start is the tick on which pwm_cnt wraps back to 0.
    assign pstart  = tick && (pwm_cnt == CNT_LAST);
    assign cfg_acc = cfg_valid && cfg_ready;
    assign ch_ok   = ({1'b0, cfg_ch} < NUM_CH_L);

    // Timebase, handshake and status outputs.
    always_ff @(posedge hw_clk or negedge rst_n) begin
        if (!rst_n) begin
            presc         <= '0;
            pwm_cnt       <= '0;
            period_strobe <= 1'b0;
            cfg_ready     <= 1'b0;
            cfg_err       <= 1'b0;
        end else begin
            presc         <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
            period_strobe <= pstart;
            cfg_ready     <= 1'b1;
            cfg_err       <= cfg_acc && !ch_ok;
        end
    end

    // Blink phase is shared by all channels so blinking LEDs stay in step.
    always_ff @(posedge hw_clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else if (pstart) begin
            if (blink_cnt == BK_LAST) begin
                blink_cnt <= '0;
                blink_ph  <= ~blink_ph;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        mode_e            shd_mode;
        mode_e            act_mode;
        logic [PWM_W-1:0] shd_duty;
        logic [PWM_W-1:0] act_duty;
        logic [PWM_W-1:0] level;
        logic             dir_down;
        logic [BD_W-1:0]  bcnt;
        logic [PWM_W-1:0] eff_lin;
        logic [PWM_W-1:0] eff;
        logic             wr_hit;

        // An out-of-range cfg_ch never matches any generated index, so it writes nothing.
        assign wr_hit = cfg_acc && (cfg_ch == 3'(i));

        always_ff @(posedge hw_clk or negedge rst_n) begin
            if (!rst_n) begin
                shd_mode <= MODE_OFF;
                shd_duty <= '0;
                act_mode <= MODE_OFF;
                act_duty <= '0;
                level    <= '0;
                dir_down <= 1'b0;
                bcnt     <= '0;
            end else begin
                // A write coinciding with pstart lands in the shadow after the
                // copy below, so it takes effect one period later.
                if (wr_hit) begin
                    shd_mode <= mode_e'(cfg_mode);
                    shd_duty <= cfg_duty;
                end
                if (pstart) begin
                    act_mode <= shd_mode;
                    act_duty <= shd_duty;
                    if (shd_mode == MODE_BREATHE && act_mode != MODE_BREATHE) begin
                        level    <= '0;
                        dir_down <= 1'b0;
                        bcnt     <= '0;
                    end else if (act_mode == MODE_BREATHE) begin
                        if (bcnt == BD_LAST) begin
                            bcnt <= '0;
                            // Turn around on arrival at either end so the peak
                            // and the floor are each held for a single step.
                            if (!dir_down) begin
                                level <= level + 1'b1;
                                if (level == LVL_TOP_M1) begin
                                    dir_down <= 1'b1;
                                end
                            end else begin
                                level <= level - 1'b1;
                                if (level == PWM_W'(1)) begin
                                    dir_down <= 1'b0;
                                end
                            end
                        end else begin
                            bcnt <= bcnt + 1'b1;
                        end
                    end
                end
            end
        end

        always_comb begin
            eff_lin = '0;
            case (act_mode)
                MODE_STATIC:  eff_lin = act_duty;
                MODE_BREATHE: eff_lin = PWM_W'(({{PWM_W{1'b0}}, level} *
                                                 {{PWM_W{1'b0}}, act_duty}) >> PWM_W);
                MODE_BLINK:   eff_lin = blink_ph ? act_duty : '0;
                default:      eff_lin = '0;
            endcase
`ifdef RGB_PWM_GAMMA_EN
            // OFF already yields 0, and 0 squared stays 0.
            eff = PWM_W'(({{PWM_W{1'b0}}, eff_lin} * {{PWM_W{1'b0}}, eff_lin}) >> PWM_W);
`else
            eff = eff_lin;
`endif
        end

        assign pwm_nxt[i] = (pwm_cnt < eff);
    end

    always_ff @(posedge hw_clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out <= '0;
        end else begin
            pwm_out <= pwm_nxt;
        end
    end

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// Purpose     : randomized scoreboard bench for rgb_pwm_ctrl against a period-level reference model.
// Latency     : expected per-period duties are queued at each modelled period start and checked per strobe.
// Backpressure: the bench assumes cfg_ready stays high after reset release.
module tb_rgb_pwm_ctrl;

    localparam int NCH      = 3;
    localparam int PER      = 256;
    localparam int BDIV     = 1;
    localparam int KDIV     = 2;
    localparam int LAST_PER = 150;

    logic             hw_clk    = 1'b0;
    logic             rst_n     = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [2:0]       cfg_ch    = 3'd0;
    logic [1:0]       cfg_mode  = 2'd0;
    logic [7:0]       cfg_duty  = 8'd0;
    logic             cfg_ready;
    logic             cfg_err;
    logic             period_strobe;
    logic [NCH-1:0]   pwm_out;

    logic             cfg_ready_d;
    logic             cfg_err_d;
    logic             period_strobe_d;
    logic [2:0]       pwm_out_d;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    bit mon_en = 1'b0;

    typedef struct packed {
        int                   edge_k;
        logic [NCH-1:0][7:0]  eff;
    } exp_t;

    exp_t exp_q[$];
    int   err_q[$];

    always #5 hw_clk = ~hw_clk;

    rgb_pwm_ctrl #(
        .NUM_CH(NCH), .PWM_W(8), .PRESCALE(1), .BREATH_DIV(BDIV), .BLINK_DIV(KDIV)
    ) u_dut (
        .hw_clk(hw_clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_duty(cfg_duty),
        .cfg_err(cfg_err), .pwm_out(pwm_out), .period_strobe(period_strobe)
    );

    // Default-parameter instance, used for reset and first-strobe timing.
    rgb_pwm_ctrl u_dut_d (
        .hw_clk(hw_clk), .rst_n(rst_n),
        .cfg_valid(1'b0), .cfg_ready(cfg_ready_d),
        .cfg_ch(3'd0), .cfg_mode(2'd0), .cfg_duty(8'd0),
        .cfg_err(cfg_err_d), .pwm_out(pwm_out_d), .period_strobe(period_strobe_d)
    );

    always @(posedge hw_clk or negedge rst_n) begin
        if (!rst_n) edge_n <= 0;
        else        edge_n <= edge_n + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Effective duty from the mode rules: breathing level is a triangle wave
    // over periods since entry, blink phase follows the global period count.
    function automatic int model_eff(input int mode, input int duty, input int since, input int pcount);
        int v;
        int s;
        int lvl;
        v = 0;
        case (mode)
            1: v = duty;
            2: begin
                s   = (since / BDIV) % 510;
                lvl = (s <= 255) ? s : 510 - s;
                v   = (lvl * duty) / 256;
            end
            3: v = ((pcount / KDIV) % 2 == 1) ? duty : 0;
            default: v = 0;
        endcase
`ifdef RGB_PWM_GAMMA_EN
        if (mode != 0) v = (v * v) / 256;
`endif
        return v;
    endfunction

    // Monitor: counts high cycles per channel between strobes and checks
    // that the highs form one run directly after the period start.
    exp_t cur = '0;
    int   off = 0;
    int   hi[NCH];
    int   stray[NCH];

    always @(negedge hw_clk) begin
        if (mon_en) begin
            if (period_strobe) begin
                for (int c = 0; c < NCH; c++) begin
                    checks++;
                    if (hi[c] != int'(cur.eff[c]) || stray[c] != 0) begin
                        errors++;
                        $display("FAIL period_ch%0d (period from edge %0d): high=%0d stray=%0d, expected high=%0d stray=0",
                                 c, cur.edge_k, hi[c], stray[c], cur.eff[c]);
                    end
                    hi[c]    = 0;
                    stray[c] = 0;
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL strobe_extra: strobe at edge %0d, expected none", edge_n);
                end else begin
                    cur = exp_q.pop_front();
                    chk("strobe_edge", edge_n, cur.edge_k);
                end
                off = 0;
            end else begin
                off++;
            end
            for (int c = 0; c < NCH; c++) begin
                if (pwm_out[c]) begin
                    if (off >= 1 && off <= int'(cur.eff[c])) hi[c]++;
                    else                                     stray[c]++;
                end
            end
            if (cfg_err) begin
                if (err_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cfg_err_extra: pulse at edge %0d, expected none", edge_n);
                end else begin
                    chk("cfg_err_edge", edge_n, err_q.pop_front());
                end
            end
        end
    end

    // First period strobe of the default instance: PRESCALE 4 * 256 ticks.
    initial begin : d_chk
        bit found;
        int at;
        found = 1'b0;
        at    = -1;
        wait (rst_n === 1'b1);
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge hw_clk);
            if (period_strobe_d) begin
                found = 1'b1;
                at    = edge_n;
            end
        end
        chk("first_strobe_d", at, 1024);
        chk("cfg_err_d_idle", int'(cfg_err_d), 0);
    end

    initial begin : stim
        int   pc;
        int   entry[NCH];
        int   smode[NCH];
        int   sduty[NCH];
        int   amode[NCH];
        int   aduty[NCH];
        bit   wv;
        int   wch;
        int   wmode;
        int   wduty;
        exp_t e;

        pc = 0;
        for (int c = 0; c < NCH; c++) begin
            entry[c] = 0; smode[c] = 0; sduty[c] = 0; amode[c] = 0; aduty[c] = 0;
        end

        repeat (3) @(negedge hw_clk);
        chk("rst_pwm_out",     int'(pwm_out),       0);
        chk("rst_cfg_ready",   int'(cfg_ready),     0);
        chk("rst_strobe",      int'(period_strobe), 0);
        chk("rst_cfg_err",     int'(cfg_err),       0);
        chk("rst_pwm_out_d",   int'(pwm_out_d),     0);
        chk("rst_cfg_ready_d", int'(cfg_ready_d),   0);
        rst_n = 1'b1;

        for (int k = 1; k <= LAST_PER * PER + 50; k++) begin
            wv    = 1'b0;
            wch   = int'($urandom_range(0, 7));
            wmode = int'($urandom_range(0, 3));
            wduty = int'($urandom_range(0, 255));
            case (k)
                5:               begin wv = 1'b1; wch = 0; wmode = 1; wduty = 64;  end
                6:               begin wv = 1'b1; wch = 1; wmode = 1; wduty = 10;  end
                7:               begin wv = 1'b1; wch = 2; wmode = 2; wduty = 255; end
                2 * PER + 100:   begin wv = 1'b1; wch = 5; wmode = 3; wduty = 77;  end
                2 * PER + 101:   begin wv = 1'b1; wch = 7; wmode = 1; wduty = 1;   end
                2 * PER + 102:   begin wv = 1'b1; wch = 1; wmode = 1; wduty = 10;  end
                3 * PER + 100:   begin wv = 1'b1; wch = 1; wmode = 1; wduty = 200; end
                4 * PER:         begin wv = 1'b1; wch = 0; wmode = 3; wduty = 255; end
                141 * PER + 3:   begin wv = 1'b1; wch = 0; wmode = 3; wduty = 255; end
                141 * PER + 4:   begin wv = 1'b1; wch = 1; wmode = 1; wduty = 200; end
                default: begin
                    // Channel 2 is left breathing so its ramp passes level 128.
                    if (k > 10 * PER && k < 140 * PER && $urandom_range(0, 199) == 0) begin
                        wv = 1'b1;
                        if (wch == 2) wch = 6;
                    end
                end
            endcase
            cfg_valid = wv;
            cfg_ch    = 3'(wch);
            cfg_mode  = 2'(wmode);
            cfg_duty  = 8'(wduty);

            @(posedge hw_clk);
            if (k % PER == 0) begin
                pc++;
                e.edge_k = k;
                for (int c = 0; c < NCH; c++) begin
                    if (smode[c] == 2 && amode[c] != 2) entry[c] = pc;
                    amode[c]    = smode[c];
                    aduty[c]    = sduty[c];
                    e.eff[c]    = 8'(model_eff(amode[c], aduty[c], pc - entry[c], pc));
                end
                exp_q.push_back(e);
            end
            if (wv) begin
                if (wch < NCH) begin
                    smode[wch] = wmode;
                    sduty[wch] = wduty;
                end else begin
                    err_q.push_back(k);
                end
            end
            #1;
            if (k == 1) begin
                chk("ready_after_release",   int'(cfg_ready),   1);
                chk("ready_after_release_d", int'(cfg_ready_d), 1);
                mon_en = 1'b1;
            end
        end

        cfg_valid = 1'b0;
        mon_en    = 1'b0;
        // Channel 1 is STATIC 200 and the period is 50 cycles in: it is high.
        chk("pre_reset_ch1_high", int'(pwm_out[1]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pwm_out", int'(pwm_out),       0);
        chk("async_rst_ready",   int'(cfg_ready),     0);
        chk("async_rst_strobe",  int'(period_strobe), 0);
        chk("pending_periods",   exp_q.size(),        0);
        chk("pending_cfg_err",   err_q.size(),        0);
        #20;
        rst_n = 1'b1;
        repeat (5) @(negedge hw_clk);
        chk("post_rst_pwm_out", int'(pwm_out), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
